uart_rx_deserializer: RTL and testbench

//  UART receive front end: synchronizes the serial line, detects a start bit, samples

---
 rtl/uart_rx_deserializer_if.sv | 30 +++
 rtl/uart_rx_deserializer.sv | 133 +++++++++++++
 tb/tb_uart_rx_deserializer.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_deserializer_if.sv
// UART receive bus: serial line in, received frame and status out.
// Ports: rx (line), Rxbuff/rx_parity/parity_en (frame + enable), framing_error, busy.
interface uart_rx_deserializer_if #(
    parameter int RxNbit = 8
);
    logic              rx;
    logic [RxNbit-1:0] Rxbuff;
    logic              rx_parity;
    logic              parity_en;
    logic              framing_error;
    logic              busy;

    modport master (
        input  rx,
        output Rxbuff,
        output rx_parity,
        output parity_en,
        output framing_error,
        output busy
    );

    modport slave (
        output rx,
        input  Rxbuff,
        input  rx_parity,
        input  parity_en,
        input  framing_error,
        input  busy
    );
endinterface

// File: rtl/uart_rx_deserializer.sv
// UART receive front end: sync, start detect, mid-bit sampling of data/parity/stop.
// Ports: clk, reset (sync active-low), bus (master side of uart_rx_deserializer_if).
module uart_rx_deserializer #(
    parameter int RxNbit       = 8,
    parameter int CLKS_PER_BIT = 434
) (
    input  logic                    clk,
    input  logic                    reset,
    uart_rx_deserializer_if.master  bus
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = (RxNbit > 1) ? $clog2(RxNbit) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic              r_sync1;
    logic              r_sync2;
    logic              r_prev;
    logic [CW-1:0]     r_cnt;
    logic [IW-1:0]     r_idx;
    logic [RxNbit-1:0] r_shift;
    logic              r_par;
    logic [RxNbit-1:0] r_rxbuff;
    logic              r_rx_parity;
    logic              r_ferr;

    logic w_rx_s;
    logic w_fall;
    logic w_cnt_end;
    logic w_cnt_half;
    logic w_last_bit;

    assign w_rx_s     = r_sync2;
    assign w_fall     = r_prev & ~w_rx_s;
    assign w_cnt_end  = (r_cnt == CW'(CLKS_PER_BIT - 1));
    assign w_cnt_half = (r_cnt == CW'(CLKS_PER_BIT / 2 - 1));
    assign w_last_bit = (r_idx == IW'(RxNbit - 1));

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:   if (w_fall) w_next = S_START;
            S_START:  if (w_cnt_half) w_next = w_rx_s ? S_IDLE : S_DATA;
            S_DATA:   if (w_cnt_end && w_last_bit) w_next = S_PARITY;
            S_PARITY: if (w_cnt_end) w_next = S_STOP;
            S_STOP:   if (w_cnt_end) w_next = S_DONE;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // The result registers load on the stop-bit sample so they are
    // already valid during the DONE cycle, when parity_en is high.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_sync1     <= 1'b1;
            r_sync2     <= 1'b1;
            r_prev      <= 1'b1;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_shift     <= '0;
            r_par       <= 1'b0;
            r_rxbuff    <= '0;
            r_rx_parity <= 1'b0;
            r_ferr      <= 1'b0;
        end else begin
            r_sync1 <= bus.rx;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            case (r_state)
                S_START: begin
                    if (w_cnt_half) begin
                        r_cnt <= '0;
                        r_idx <= '0;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_DATA: begin
                    if (w_cnt_end) begin
                        r_shift[r_idx] <= w_rx_s;
                        r_idx          <= r_idx + IW'(1);
                        r_cnt          <= '0;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_PARITY: begin
                    if (w_cnt_end) begin
                        r_par <= w_rx_s;
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_STOP: begin
                    if (w_cnt_end) begin
                        r_rxbuff    <= r_shift;
                        r_rx_parity <= r_par;
                        r_ferr      <= ~w_rx_s;
                        r_cnt       <= '0;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: r_cnt <= '0;
            endcase
        end
    end

    assign bus.Rxbuff        = r_rxbuff;
    assign bus.rx_parity     = r_rx_parity;
    assign bus.framing_error = r_ferr;
    assign bus.parity_en     = (r_state == S_DONE);
    assign bus.busy          = (r_state != S_IDLE);
endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Self-checking bench for uart_rx_deserializer (CLKS_PER_BIT=8, RxNbit=8).
// Frames are modelled as expected {data, parity, framing_error} entries.
module tb_uart_rx_deserializer;
    localparam int NB  = 8;
    localparam int CPB = 8;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    uart_rx_deserializer_if #(.RxNbit(NB)) bus ();

    uart_rx_deserializer #(
        .RxNbit(NB),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    typedef struct packed {
        logic [7:0] d;
        logic       p;
        logic       fe;
    } frm_t;

    frm_t cap_q[$];
    frm_t exp_q[$];

    always @(negedge clk) begin
        if (reset && bus.parity_en)
            cap_q.push_back('{d: bus.Rxbuff, p: bus.rx_parity, fe: bus.framing_error});
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic hold(input logic v, input int n);
        bus.rx = v;
        repeat (n) @(negedge clk);
    endtask

    // la/lb: lengths of even/odd numbered bits (start bit is bit 0)
    task automatic send(input logic [7:0] d, input logic p, input logic s,
                        input int la, input int lb);
        hold(1'b0, la);
        for (int i = 0; i < 8; i++)
            hold(d[i], ((i + 1) % 2 == 0) ? la : lb);
        hold(p, lb);
        hold(s, la);
        exp_q.push_back('{d: d, p: p, fe: ~s});
    endtask

    task automatic settle(input string tag);
        frm_t c;
        frm_t e;
        int   n = 0;
        while (cap_q.size() < exp_q.size() && n < 400) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
        chk({tag, "_npulse"}, 32'(cap_q.size()), 32'(exp_q.size()));
        while (cap_q.size() > 0 && exp_q.size() > 0) begin
            c = cap_q.pop_front();
            e = exp_q.pop_front();
            chk({tag, "_data"}, 32'(c.d), 32'(e.d));
            chk({tag, "_par"}, 32'(c.p), 32'(e.p));
            chk({tag, "_ferr"}, 32'(c.fe), 32'(e.fe));
        end
        cap_q.delete();
        exp_q.delete();
    endtask

    initial begin
        logic [7:0] saved;
        logic [7:0] rd;
        logic       rp;
        logic       rs;

        bus.rx = 1'b1;
        reset  = 1'b0;
        repeat (5) @(negedge clk);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_pe", 32'(bus.parity_en), 32'd0);
        chk("rst_buf", 32'(bus.Rxbuff), 32'd0);
        chk("rst_par", 32'(bus.rx_parity), 32'd0);
        chk("rst_ferr", 32'(bus.framing_error), 32'd0);
        reset = 1'b1;
        hold(1'b1, 10);

        // good frame
        send(8'hA5, 1'b0, 1'b1, CPB, CPB);
        hold(1'b1, 16);
        settle("t1");
        chk("t1_busy", 32'(bus.busy), 32'd0);

        // bad stop, line stuck low, then recovery
        send(8'h3C, 1'b1, 1'b0, CPB, CPB);
        hold(1'b0, 40);
        settle("t2");
        chk("t2_busy_low", 32'(bus.busy), 32'd0);
        chk("t2_ferr_held", 32'(bus.framing_error), 32'd1);
        hold(1'b1, 16);
        send(8'h01, 1'b1, 1'b1, CPB, CPB);
        hold(1'b1, 16);
        settle("t2b");
        chk("t2b_ferr", 32'(bus.framing_error), 32'd0);

        // glitch / false start
        saved = bus.Rxbuff;
        hold(1'b0, 2);
        hold(1'b1, 2);
        chk("t3_busy_hi", 32'(bus.busy), 32'd1);
        hold(1'b1, 4);
        chk("t3_busy_lo", 32'(bus.busy), 32'd0);
        hold(1'b1, 20);
        settle("t3");
        chk("t3_buf", 32'(bus.Rxbuff), 32'(saved));

        // back-to-back
        send(8'h00, 1'b0, 1'b1, CPB, CPB);
        send(8'hFF, 1'b1, 1'b1, CPB, CPB);
        hold(1'b1, 16);
        settle("t4");

        // reset mid-DATA of 0x5A
        hold(1'b0, CPB);
        hold(1'b0, CPB);
        hold(1'b1, CPB);
        hold(1'b0, 4);
        chk("t5_busy_mid", 32'(bus.busy), 32'd1);
        reset = 1'b0;
        @(negedge clk);
        chk("t5_buf", 32'(bus.Rxbuff), 32'd0);
        chk("t5_busy", 32'(bus.busy), 32'd0);
        chk("t5_pe", 32'(bus.parity_en), 32'd0);
        chk("t5_par", 32'(bus.rx_parity), 32'd0);
        chk("t5_ferr", 32'(bus.framing_error), 32'd0);
        bus.rx = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        hold(1'b1, 16);
        send(8'h81, 1'b0, 1'b1, CPB, CPB);
        hold(1'b1, 16);
        settle("t5");

        // bit period skew
        send(8'h96, 1'b1, 1'b1, CPB - 1, CPB + 1);
        hold(1'b1, 16);
        send(8'h96, 1'b0, 1'b1, CPB + 1, CPB - 1);
        hold(1'b1, 16);
        settle("t6");

        // random frames
        for (int r = 0; r < 24; r++) begin
            rd = 8'($urandom);
            rp = 1'($urandom);
            rs = ($urandom_range(0, 3) != 0);
            send(rd, rp, rs, CPB, CPB);
            if (!rs)
                hold(1'b1, CPB + $urandom_range(0, 8));
            else if ($urandom_range(0, 1) != 0)
                hold(1'b1, $urandom_range(1, 10));
            if (r % 6 == 5) begin
                hold(1'b1, 16);
                settle("rnd");
            end
        end
        hold(1'b1, 16);
        settle("rnd_end");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
